tcm_ifetch_queue: RTL and testbench

Instruction fetch front-end that drives the TCM instruction port (rd/pc in, one-cycle-later valid/inst out) and buffers the returned words in a small in-order FIFO for the decode stage. It generates sequential PCs, handles branch redirects by discarding stale in-flight responses, and pulses TCM flush/invalidate on fence.i. It sits directly upstream of the TCM instruction port and downstream of the core's branch/fence logic.

---
 rtl/tcm_ifetch_queue.sv | 112 +++++++++++
 tb/tb_tcm_ifetch_queue.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tcm_ifetch_queue.sv
// tcm_ifetch_queue: TCM instruction fetch front-end with in-order response FIFO and branch discard.
// Optional macro TCM_IFQ_ERROR_EN stores mem_i_error_i per entry and reports it on inst_error_o.
module tcm_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic        fence_i_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_error_o,
  input  logic        inst_ready_i,
  output logic        mem_i_rd_o,
  output logic [31:0] mem_i_pc_o,
  output logic        mem_i_flush_o,
  output logic        mem_i_invalidate_o,
  input  logic        mem_i_accept_i,
  input  logic        mem_i_valid_i,
  input  logic        mem_i_error_i,
  input  logic [31:0] mem_i_inst_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
  logic [AW-1:0] wr_q, rd_q, iwr_q, ird_q;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   ifl_pc_q    [DEPTH];
  logic          flush_q;
  logic          issue, resp, push, pop;
  logic [CW:0]   credit;
  logic          unused_bits;

  assign credit             = {1'b0, cnt_q} + {1'b0, out_q};
  assign mem_i_rd_o         = fetch_en_i & ~branch_i & (credit < LIM);
  assign mem_i_pc_o         = pc_q;
  assign issue              = mem_i_rd_o & mem_i_accept_i;
  assign resp               = mem_i_valid_i & (out_q != '0);
  // Responses landing in a branch cycle belong to the old stream and are dropped.
  assign push               = resp & (disc_q == '0) & ~branch_i;
  assign pop                = inst_valid_o & inst_ready_i & ~branch_i;
  assign inst_valid_o       = cnt_q != '0;
  assign inst_o             = fifo_inst_q[rd_q];
  assign pc_o               = fifo_pc_q[rd_q];
  assign mem_i_flush_o      = flush_q;
  assign mem_i_invalidate_o = flush_q;

  always_comb begin
    pc_d   = branch_i ? {branch_pc_i[31:2], 2'b00} : issue ? pc_q + 32'd4 : pc_q;
    out_d  = out_q + CW'(issue) - CW'(resp);
    disc_d = branch_i ? out_q - CW'(resp) : disc_q - CW'(resp & (disc_q != '0));
    cnt_d  = branch_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      out_q       <= '0;
      disc_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      iwr_q       <= '0;
      ird_q       <= '0;
      flush_q     <= 1'b0;
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      ifl_pc_q    <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      flush_q <= fence_i_i;
      if (issue) begin
        ifl_pc_q[iwr_q] <= pc_q;
        iwr_q           <= iwr_q + AW'(1);
      end
      if (resp) ird_q <= ird_q + AW'(1);
      if (push) begin
        fifo_inst_q[wr_q] <= mem_i_inst_i;
        fifo_pc_q[wr_q]   <= ifl_pc_q[ird_q];
        wr_q              <= wr_q + AW'(1);
      end
      if (branch_i) rd_q <= wr_q;
      else if (pop) rd_q <= rd_q + AW'(1);
    end
  end

`ifdef TCM_IFQ_ERROR_EN
  logic fifo_err_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fifo_err_q <= '{default: 1'b0};
    else if (push) fifo_err_q[wr_q] <= mem_i_error_i;
  end

  assign inst_error_o = fifo_err_q[rd_q];
  assign unused_bits  = ^branch_pc_i[1:0];
`else
  assign inst_error_o = 1'b0;
  assign unused_bits  = ^{branch_pc_i[1:0], mem_i_error_i};
`endif
endmodule

// File: tb/tb_tcm_ifetch_queue.sv
// tb_tcm_ifetch_queue: directed vector table plus hand sequences against a queued 1-cycle TCM model.
module tb_tcm_ifetch_queue;
`ifdef TCM_IFQ_ERROR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0, rst_n;
  logic fe, br, fence, rdy;
  logic [31:0] bpc;
  logic vld, err, rd, flush, inval;
  logic [31:0] inst, pc_o, mpc;
  logic m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_inst = '0;
  logic accept = 1'b1;
  bit hold;
  logic [31:0] mq [$];
  logic [31:0] m_p;
  int total = 0, bad = 0;

  typedef struct {
    bit fe, rdy, rd;
    logic [31:0] mpc;
    bit vld;
    logic [31:0] hpc;
  } vec_t;
  vec_t tv [13];

  always #5 clk = ~clk;

  tcm_ifetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fe), .branch_i(br), .branch_pc_i(bpc),
    .fence_i_i(fence), .inst_valid_o(vld), .inst_o(inst), .pc_o(pc_o), .inst_error_o(err),
    .inst_ready_i(rdy), .mem_i_rd_o(rd), .mem_i_pc_o(mpc), .mem_i_flush_o(flush),
    .mem_i_invalidate_o(inval), .mem_i_accept_i(accept), .mem_i_valid_i(m_valid),
    .mem_i_error_i(m_err), .mem_i_inst_i(m_inst)
  );

  function automatic logic [31:0] mk(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction

  // TCM model: answers accepted requests one cycle later unless held back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid <= 1'b0;
    end else begin
      if (rd && accept) mq.push_back(mpc);
      if (!hold && mq.size() != 0) begin
        m_p = mq.pop_front();
        m_valid <= 1'b1;
        m_inst  <= mk(m_p);
        m_err   <= (m_p == 32'h8);
      end else m_valid <= 1'b0;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{1, 1, 1, 32'h00, 0, 32'h00};
    tv[1]  = '{1, 1, 1, 32'h04, 0, 32'h00};
    tv[2]  = '{1, 1, 1, 32'h08, 1, 32'h00};
    tv[3]  = '{1, 1, 1, 32'h0C, 1, 32'h04};
    tv[4]  = '{1, 0, 1, 32'h10, 1, 32'h08};
    tv[5]  = '{1, 0, 1, 32'h14, 1, 32'h08};
    tv[6]  = '{1, 0, 0, 32'h18, 1, 32'h08};
    tv[7]  = '{1, 0, 0, 32'h18, 1, 32'h08};
    tv[8]  = '{1, 1, 0, 32'h18, 1, 32'h08};
    tv[9]  = '{1, 1, 1, 32'h18, 1, 32'h0C};
    tv[10] = '{1, 1, 1, 32'h1C, 1, 32'h10};
    tv[11] = '{1, 1, 1, 32'h20, 1, 32'h14};
    tv[12] = '{1, 1, 1, 32'h24, 1, 32'h18};
    rst_n = 1'b0; fe = 0; rdy = 0; br = 0; bpc = '0; fence = 0; hold = 0;
    repeat (3) step();
    #1;
    chk("rst_vld", vld, 0); chk("rst_inst", inst, 0); chk("rst_pc", pc_o, 0);
    chk("rst_err", err, 0); chk("rst_rd", rd, 0); chk("rst_flush", flush, 0);
    chk("rst_inval", inval, 0); chk("rst_mpc", mpc, 0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(); fe = tv[i].fe; rdy = tv[i].rdy; #1;
      chk($sformatf("v%0d_rd", i), rd, tv[i].rd);
      chk($sformatf("v%0d_mpc", i), mpc, tv[i].mpc);
      chk($sformatf("v%0d_vld", i), vld, tv[i].vld);
      if (tv[i].vld) begin
        chk($sformatf("v%0d_pc", i), pc_o, tv[i].hpc);
        chk($sformatf("v%0d_inst", i), inst, mk(tv[i].hpc));
      end
      chk($sformatf("v%0d_err", i), err, ERR && tv[i].vld && tv[i].hpc == 32'h8);
    end
    step(); br = 1; bpc = 32'h103; #1;
    chk("br_rd", rd, 0); chk("br_mpc", mpc, 32'h28);
    step(); br = 0; #1;
    chk("br1_vld", vld, 0); chk("br1_rd", rd, 1); chk("br1_mpc", mpc, 32'h100);
    step(); #1;
    chk("br2_vld", vld, 0); chk("br2_mpc", mpc, 32'h104);
    step(); #1;
    chk("br3_vld", vld, 1); chk("br3_pc", pc_o, 32'h100);
    chk("br3_inst", inst, mk(32'h100)); chk("br3_mpc", mpc, 32'h108);
    step(); br = 1; bpc = 32'hFFFF_FFF8;
    step(); br = 0; #1;
    chk("w0_mpc", mpc, 32'hFFFF_FFF8); chk("w0_rd", rd, 1);
    step(); #1; chk("w1_mpc", mpc, 32'hFFFF_FFFC);
    step(); #1; chk("w2_mpc", mpc, 32'h0); chk("w2_vld", vld, 1); chk("w2_pc", pc_o, 32'hFFFF_FFF8);
    step(); #1; chk("w3_pc", pc_o, 32'hFFFF_FFFC); chk("w3_mpc", mpc, 32'h4);
    step(); #1; chk("w4_pc", pc_o, 32'h0); chk("w4_mpc", mpc, 32'h8);
    step(); fence = 1; #1;
    chk("f0_flush", flush, 0); chk("f0_mpc", mpc, 32'hC); chk("f0_pc", pc_o, 32'h4);
    step(); fence = 0; #1;
    chk("f1_flush", flush, 1); chk("f1_inval", inval, 1); chk("f1_mpc", mpc, 32'h10);
    chk("f1_pc", pc_o, 32'h8); chk("f1_err", err, ERR);
    step(); #1;
    chk("f2_flush", flush, 0); chk("f2_inval", inval, 0); chk("f2_mpc", mpc, 32'h14);
    chk("f2_pc", pc_o, 32'hC); chk("f2_err", err, 0);
    step(); hold = 1;
    repeat (4) step();
    br = 1; bpc = 32'h200;
    step(); br = 0; hold = 0;
    begin
      int k = 0;
      while (!vld && k < 40) begin
        step(); k++;
      end
      #1;
      chk("disc_timeout", k < 40, 1);
    end
    chk("disc_pc", pc_o, 32'h200); chk("disc_inst", inst, mk(32'h200));
    step(); #1; chk("disc_pc2", pc_o, 32'h204);
    step(); #2; rst_n = 0; fe = 0; #1;
    chk("mr_vld", vld, 0); chk("mr_pc", pc_o, 0); chk("mr_inst", inst, 0);
    chk("mr_rd", rd, 0); chk("mr_mpc", mpc, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
